// File: rtl/mem_access_pkg.sv
// Shared definitions for the MEM pipeline stage: opcodes, operation codes,
// bus widths, constants and the FSM state encoding.
package mem_access_pkg;

  localparam int DATA_W      = 32;
  localparam int REG_ADDR_W  = 5;
  localparam int OPCODE_W    = 7;
  localparam int OPT_W       = 5;
  localparam int STALL_W     = 6;
  localparam int STALL_EXMEM = 3;  // stall bit that freezes the EX/MEM register

  localparam logic              ENABLE    = 1'b1;
  localparam logic              DISABLE   = 1'b0;
  localparam logic [DATA_W-1:0] ZERO_WORD = '0;
  localparam logic [STALL_W-1:0] NO_STOP  = '0;

  localparam logic [OPCODE_W-1:0] OP_LOAD  = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OP_STORE = 7'b0100011;

  localparam logic [OPT_W-1:0] OPT_NOP = 5'h00;
  localparam logic [OPT_W-1:0] OPT_LB  = 5'h01;
  localparam logic [OPT_W-1:0] OPT_LH  = 5'h02;
  localparam logic [OPT_W-1:0] OPT_LW  = 5'h03;
  localparam logic [OPT_W-1:0] OPT_LBU = 5'h04;
  localparam logic [OPT_W-1:0] OPT_LHU = 5'h05;
  localparam logic [OPT_W-1:0] OPT_SB  = 5'h06;
  localparam logic [OPT_W-1:0] OPT_SH  = 5'h07;
  localparam logic [OPT_W-1:0] OPT_SW  = 5'h08;
  localparam logic [OPT_W-1:0] OPT_ADD = 5'h09;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_STORE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Number of bytes moved by a memory operation; 0 for anything else.
  function automatic logic [2:0] opt_bytes(input logic [OPT_W-1:0] opt);
    case (opt)
      OPT_LB, OPT_LBU, OPT_SB: return 3'd1;
      OPT_LH, OPT_LHU, OPT_SH: return 3'd2;
      OPT_LW, OPT_SW:          return 3'd4;
      default:                 return 3'd0;
    endcase
  endfunction

  function automatic logic is_load_opt(input logic [OPT_W-1:0] opt);
    return (opt == OPT_LB) || (opt == OPT_LH) || (opt == OPT_LW) ||
           (opt == OPT_LBU) || (opt == OPT_LHU);
  endfunction

  function automatic logic is_store_opt(input logic [OPT_W-1:0] opt);
    return (opt == OPT_SB) || (opt == OPT_SH) || (opt == OPT_SW);
  endfunction

endpackage

// File: rtl/mem_access_if.sv
// Byte-wide synchronous RAM port. The MEM stage is the master; the RAM
// returns read data one cycle after the address is presented.
interface mem_access_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] mem_a;
  logic [7:0]        mem_dout;
  logic              mem_wr;
  logic [7:0]        mem_din;

  modport master (output mem_a, output mem_dout, output mem_wr, input  mem_din);
  modport slave  (input  mem_a, input  mem_dout, input  mem_wr, output mem_din);
endinterface

// File: rtl/mem_access_load_ext.sv
// Little-endian assembly of load bytes plus sign/zero extension. The last
// byte always comes straight from the RAM read port.
module mem_access_load_ext
  import mem_access_pkg::*;
(
  input  logic [OPT_W-1:0]  i_opt,
  input  logic [7:0]        i_b0,
  input  logic [7:0]        i_b1,
  input  logic [7:0]        i_b2,
  input  logic [7:0]        i_din,
  output logic [DATA_W-1:0] o_word
);

  // Select the byte lanes for the access size and extend to a full word.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    o_word = ZERO_WORD;
    case (i_opt)
      OPT_LB:  o_word = {{24{i_din[7]}}, i_din};
      OPT_LBU: o_word = {24'h000000, i_din};
      OPT_LH:  o_word = {{16{i_din[7]}}, i_din, i_b0};
      OPT_LHU: o_word = {16'h0000, i_din, i_b0};
      OPT_LW:  o_word = {i_din, i_b2, i_b1, i_b0};
      default: o_word = ZERO_WORD;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// MEM pipeline stage: byte-serial loads and stores over an 8-bit synchronous
// RAM port, stall request while an access is in flight, MEM/WB drive.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 32
)(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [OPCODE_W-1:0]   mem_opcode,
  input  logic [OPT_W-1:0]      mem_opt,
  input  logic                  mem_we,
  input  logic [REG_ADDR_W-1:0] mem_waddr,
  input  logic [DATA_W-1:0]     mem_alu,
  input  logic [DATA_W-1:0]     mem_rdata2,
  input  logic [STALL_W-1:0]    stall,
  mem_access_if.master          ram,
  output logic                  stallreq,
  output logic                  wb_we,
  output logic [REG_ADDR_W-1:0] wb_waddr,
  output logic [DATA_W-1:0]     wb_wdata
);

  state_e      r_state;
  logic [2:0]  r_cnt;
  logic [7:0]  r_b0, r_b1, r_b2;
  logic [31:0] r_res;

  logic              w_is_load, w_is_store, w_hold;
  logic              w_load_last, w_store_last;
  logic [2:0]        w_nbytes;
  logic [ADDR_W-1:0] w_base, w_addr;
  logic [7:0]        w_store_byte;
  logic [31:0]       w_load_word;
  logic              w_unused_stall;

  logic [ADDR_W-1:0]     w_mem_a;
  logic [7:0]            w_mem_dout;
  logic                  w_mem_wr, w_stallreq, w_wb_we;
  logic [REG_ADDR_W-1:0] w_wb_waddr;
  logic [DATA_W-1:0]     w_wb_wdata;

  // Unknown opt codes under a LOAD/STORE opcode fall through as plain ALU results.
  assign w_is_load    = (mem_opcode == OP_LOAD)  && is_load_opt(mem_opt);
  assign w_is_store   = (mem_opcode == OP_STORE) && is_store_opt(mem_opt);
  assign w_nbytes     = opt_bytes(mem_opt);
  assign w_hold       = stall[STALL_EXMEM];
  assign w_unused_stall = ^{stall[5:4], stall[2:0]};

  // Byte address wraps naturally at ADDR_W bits.
  assign w_base       = ADDR_W'(mem_alu);
  assign w_addr       = w_base + ADDR_W'(r_cnt);
  assign w_load_last  = (r_cnt == w_nbytes);
  assign w_store_last = (r_cnt == (w_nbytes - 3'd1));

  // Store data lane for the byte currently being written.
  always_comb begin
    w_store_byte = 8'h00;
    case (r_cnt[1:0])
      2'd0: w_store_byte = mem_rdata2[7:0];
      2'd1: w_store_byte = mem_rdata2[15:8];
      2'd2: w_store_byte = mem_rdata2[23:16];
      2'd3: w_store_byte = mem_rdata2[31:24];
      default: w_store_byte = 8'h00;
    endcase
  end

  mem_access_load_ext u_load_ext (
    .i_opt  (mem_opt),
    .i_b0   (r_b0),
    .i_b1   (r_b1),
    .i_b2   (r_b2),
    .i_din  (ram.mem_din),
    .o_word (w_load_word)
  );

  // Access sequencer: byte counter, captured load bytes and held result.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 3'd0;
      r_res   <= ZERO_WORD;
      r_b0    <= 8'h00;
      r_b1    <= 8'h00;
      r_b2    <= 8'h00;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_is_load) begin
            r_state <= ST_LOAD;
            r_cnt   <= 3'd1;
          end else if (w_is_store) begin
            if (w_store_last) begin
              // Single-byte store finishes in the cycle it is seen.
              if (w_hold) begin
                r_state <= ST_DONE;
                r_res   <= mem_alu;
              end
            end else begin
              r_state <= ST_STORE;
              r_cnt   <= 3'd1;
            end
          end
        end
        ST_LOAD: begin
          if (!w_load_last) begin
            case (r_cnt)
              3'd1:    r_b0 <= ram.mem_din;
              3'd2:    r_b1 <= ram.mem_din;
              3'd3:    r_b2 <= ram.mem_din;
              default: ;
            endcase
            r_cnt <= r_cnt + 3'd1;
          end else begin
            r_cnt <= 3'd0;
            if (w_hold) begin
              r_state <= ST_DONE;
              r_res   <= w_load_word;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        ST_STORE: begin
          if (w_store_last) begin
            r_cnt <= 3'd0;
            if (w_hold) begin
              r_state <= ST_DONE;
              r_res   <= mem_alu;
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        ST_DONE: begin
          if (!w_hold) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // RAM port, stall request and MEM/WB drive; everything is forced low in reset.
  always_comb begin
    w_mem_a    = '0;
    w_mem_dout = 8'h00;
    w_mem_wr   = DISABLE;
    w_stallreq = DISABLE;
    w_wb_we    = DISABLE;
    w_wb_waddr = '0;
    w_wb_wdata = ZERO_WORD;
    if (!rst) begin
      case (r_state)
        ST_IDLE: begin
          if (w_is_load) begin
            w_mem_a    = w_addr;
            w_stallreq = ENABLE;
            w_wb_waddr = mem_waddr;
          end else if (w_is_store) begin
            w_mem_a    = w_addr;
            w_mem_dout = w_store_byte;
            w_mem_wr   = ENABLE;
            w_stallreq = !w_store_last;
            w_wb_we    = mem_we;
            w_wb_waddr = mem_waddr;
            w_wb_wdata = mem_alu;
          end else begin
            w_wb_we    = mem_we;
            w_wb_waddr = mem_waddr;
            w_wb_wdata = mem_alu;
          end
        end
        ST_LOAD: begin
          w_wb_waddr = mem_waddr;
          if (!w_load_last) begin
            w_mem_a    = w_addr;
            w_stallreq = ENABLE;
          end else begin
            w_wb_we    = mem_we;
            w_wb_wdata = w_load_word;
          end
        end
        ST_STORE: begin
          w_mem_a    = w_addr;
          w_mem_dout = w_store_byte;
          w_mem_wr   = ENABLE;
          w_stallreq = !w_store_last;
          w_wb_we    = mem_we;
          w_wb_waddr = mem_waddr;
          w_wb_wdata = mem_alu;
        end
        ST_DONE: begin
          w_wb_we    = mem_we;
          w_wb_waddr = mem_waddr;
          w_wb_wdata = r_res;
        end
        default: ;
      endcase
    end
  end

  assign ram.mem_a    = w_mem_a;
  assign ram.mem_dout = w_mem_dout;
  assign ram.mem_wr   = w_mem_wr;
  assign stallreq     = w_stallreq;
  assign wb_we        = w_wb_we;
  assign wb_waddr     = w_wb_waddr;
  assign wb_wdata     = w_wb_wdata;

endmodule
